// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: program-port-written word array with a fixed-latency
// single-outstanding fetch interface and alignment/range error reporting.
module instr_fetch_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_instr,
  output logic [1:0]                 rsp_err,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  output logic                       busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   instr_q;
  logic [1:0]          err_q;
  logic [1:0]          err_dec;
  logic                accept;
  logic                load_rsp;

  assign req_ready = (state == IDLE) && !prog_we;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_instr = rsp_valid ? instr_q : NOP_WORD;
  assign rsp_err   = rsp_valid ? err_q : 2'b00;

  // With RD_LAT=1 the response loads on the acceptance edge, before addr_q holds the address.
  assign fetch_addr = (state == IDLE) ? req_addr : addr_q;
  assign idx        = fetch_addr[IDX_W+1:2];

  always_comb begin
    err_dec = 2'b00;
    if (fetch_addr[1:0] != 2'b00) begin
      err_dec = 2'b01;
    end else if ((fetch_addr >> 2) >= ADDR_W'(DEPTH)) begin
      err_dec = 2'b10;
    end
  end

  // A program write landing on the capture edge is forwarded so it shows in the response.
  assign rd_word  = (prog_we && (prog_addr == idx)) ? prog_data : mem[idx];
  assign load_rsp = (state != RESP) && (state_next == RESP);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (RD_LAT == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      instr_q <= NOP_WORD;
      err_q   <= 2'b00;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q <= req_addr;
      end
      if (load_rsp) begin
        err_q   <= err_dec;
        instr_q <= (err_dec == 2'b00) ? rd_word : NOP_WORD;
      end
    end
  end

  // Storage has no reset so program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: three instances (RD_LAT 2, 1, 4) checked against a
// word-array reference model with directed and randomized fetches.
module tb_instr_fetch_mem;

  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_instr [3];
  logic [1:0]  rsp_err   [3];
  logic        prog_we   [3];
  logic [5:0]  prog_addr [3];
  logic [31:0] prog_data [3];
  logic        busy      [3];

  logic [31:0] model_mem [3][64];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          last_acc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_fetch_mem #(.RD_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4))) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_instr(rsp_instr[g]), .rsp_err(rsp_err[g]),
      .prog_we(prog_we[g]), .prog_addr(prog_addr[g]), .prog_data(prog_data[g]),
      .busy(busy[g])
    );
  end

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 1 : 4);
  endfunction

  // Reference: misaligned beats out-of-range; good fetches read the model array.
  function automatic void ref_model(input int sel, input logic [31:0] a,
                                    output logic [31:0] i, output logic [1:0] e);
    if (a % 4 != 0) begin
      e = 2'b01; i = NOP;
    end else if (a / 4 >= 64) begin
      e = 2'b10; i = NOP;
    end else begin
      e = 2'b00; i = model_mem[sel][a / 4];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prog_all(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      prog_we[s] = 1'b1; prog_addr[s] = 6'(idx); prog_data[s] = d;
      model_mem[s][idx] = d;
    end
  endtask

  task automatic fetch(input int sel, input logic [31:0] addr, input int hold,
                       input bit wr_in_wait, input bit b2b);
    logic [31:0] exp_i;
    logic [1:0]  exp_e;
    bit          got;
    int          seen;
    int          acc;
    int          widx;
    string       p;
    p = $sformatf("u%0d@%h", sel, addr);
    widx = int'(addr >> 2);
    @(posedge clk); #1;
    prog_we[sel] = 1'b0;
    req_valid[sel] = 1'b1; req_addr[sel] = addr; rsp_ready[sel] = (hold == 0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[sel]) begin got = 1'b1; break; end
    end
    check({p, " accept"}, 32'(got), 32'd1);
    if (!got) begin req_valid[sel] = 1'b0; return; end
    acc = cyc;
    if (b2b) check({p, " issue_gap"}, 32'(acc - last_acc[sel]), 32'(lat_of(sel) + 1));
    last_acc[sel] = acc;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    if (wr_in_wait && lat_of(sel) > 1 && addr % 4 == 0 && widx < 64) begin
      prog_we[sel] = 1'b1; prog_addr[sel] = 6'(widx); prog_data[sel] = $urandom;
      model_mem[sel][widx] = prog_data[sel];
    end
    ref_model(sel, addr, exp_i, exp_e);
    seen = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) check({p, " busy"}, 32'(busy[sel]), 32'd1);
      if (rsp_valid[sel]) begin seen = n; break; end
      if (n == 1) check({p, " idle_instr"}, rsp_instr[sel], NOP);
      @(posedge clk); #1;
      prog_we[sel] = 1'b0;
    end
    check({p, " latency"}, 32'(seen), 32'(lat_of(sel)));
    if (seen < 0) return;
    check({p, " instr"}, rsp_instr[sel], exp_i);
    check({p, " err"}, 32'(rsp_err[sel]), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      prog_we[sel] = 1'b0;
      if (h == 0 && exp_e == 2'b00) begin
        prog_we[sel] = 1'b1; prog_addr[sel] = 6'(widx); prog_data[sel] = ~exp_i;
        model_mem[sel][widx] = ~exp_i;
      end
      @(negedge clk);
      check({p, " hold_valid"}, 32'(rsp_valid[sel]), 32'd1);
      check({p, " hold_instr"}, rsp_instr[sel], exp_i);
      check({p, " hold_err"}, 32'(rsp_err[sel]), 32'(exp_e));
      check({p, " hold_ready"}, 32'(req_ready[sel]), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      prog_we[sel] = 1'b0; rsp_ready[sel] = 1'b1;
      @(negedge clk);
      check({p, " release_valid"}, 32'(rsp_valid[sel]), 32'd1);
      @(negedge clk);
      check({p, " after_ready"}, 32'(req_ready[sel]), 32'd1);
      check({p, " after_valid"}, 32'(rsp_valid[sel]), 32'd0);
      check({p, " after_instr"}, rsp_instr[sel], NOP);
      check({p, " after_busy"}, 32'(busy[sel]), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      1:       return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      2:       return ($urandom | 32'h100) & ~32'h3;
      default: return 32'($urandom_range(0, 63)) * 4;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = '0; rsp_ready[s] = 1'b1;
      prog_we[s] = 1'b0; prog_addr[s] = '0; prog_data[s] = '0; last_acc[s] = 0;
    end
    #2;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("u%0d rst_ready", s), 32'(req_ready[s]), 32'd1);
      check($sformatf("u%0d rst_valid", s), 32'(rsp_valid[s]), 32'd0);
      check($sformatf("u%0d rst_busy", s), 32'(busy[s]), 32'd0);
      check($sformatf("u%0d rst_instr", s), rsp_instr[s], NOP);
      check($sformatf("u%0d rst_err", s), 32'(rsp_err[s]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) prog_all(i, $urandom);
    prog_all(0, 32'h5800_0000);
    prog_all(1, 32'h0810_0000);

    // Program then fetch, back-to-back.
    fetch(0, 32'd0, 0, 1'b0, 1'b0);
    fetch(0, 32'd4, 0, 1'b0, 1'b1);
    // Backpressure for five cycles.
    fetch(0, 32'd8, 5, 1'b0, 1'b0);
    // Error paths and the last word.
    fetch(0, 32'd6, 0, 1'b0, 1'b0);
    fetch(0, 32'd256, 0, 1'b0, 1'b1);
    fetch(0, 32'd252, 0, 1'b0, 1'b1);

    // Program/fetch collision in IDLE.
    @(posedge clk); #1;
    prog_we[0] = 1'b1; prog_addr[0] = 6'd3; prog_data[0] = 32'hDEAD_0000;
    req_valid[0] = 1'b1; req_addr[0] = 32'd12;
    model_mem[0][3] = 32'hDEAD_0000;
    @(negedge clk);
    check("u0 collide_ready", 32'(req_ready[0]), 32'd0);
    fetch(0, 32'd12, 0, 1'b0, 1'b0);

    // Writes while waiting are visible in the response.
    fetch(0, 32'd20, 0, 1'b1, 1'b0);
    fetch(2, 32'd40, 0, 1'b1, 1'b0);

    // Reset one cycle after acceptance discards the fetch.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 32'd16;
    @(negedge clk);
    check("u0 midrst_accept", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("u0 midrst_valid", 32'(rsp_valid[0]), 32'd0);
    check("u0 midrst_busy", 32'(busy[0]), 32'd0);
    check("u0 midrst_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    check("u0 no_rsp_after_reset", 32'(seen), 32'd0);
    fetch(0, 32'd0, 0, 1'b0, 1'b0);

    // Latency sweep and randomized fetches on all three latencies.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) fetch(s, rand_addr(), 0, 1'b0, i > 0);
      fetch(s, rand_addr(), $urandom_range(1, 3), 1'b0, 1'b0);
      fetch(s, 32'($urandom_range(0, 63)) * 4, 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The block SHALL expose these parameters, one per line:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 64, number of instruction words; a power of two, at least 2.
- RD_LAT, 2, cycles from request acceptance to response valid; at least 1.
- NOP_WORD, 32'h0, word returned on any errored fetch.

REQ-002 The block SHALL expose these ports, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block accepts a request this cycle.
- req_addr  in  ADDR_W  byte address of the fetch.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- prog_we  in  1  program-port write strobe.
- prog_addr  in  log2(DEPTH)  word index to write.
- prog_data  in  DATA_W  word to write.
- busy  out  1  a fetch is in flight (state is not IDLE).

Function
REQ-003 Storage SHALL be a DEPTH x DATA_W array, written only through the program port and never cleared by reset.
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 only when the state is IDLE and prog_we=0.
REQ-006 A request SHALL be accepted when req_valid and req_ready are both 1 on a rising edge; acceptance latches req_addr and moves the FSM to WAIT, or directly to RESP when RD_LAT=1.
REQ-007 In WAIT, a counter SHALL count from 1; when it reaches RD_LAT-1 the FSM SHALL go to RESP, so rsp_valid asserts exactly RD_LAT cycles after acceptance.
REQ-008 In RESP, rsp_valid SHALL be 1 and rsp_instr and rsp_err SHALL hold stable until rsp_ready=1; the FSM then returns to IDLE.
REQ-009 The block SHALL have no same-cycle RESP-to-accept path: at most one request is outstanding, and the minimum issue interval is RD_LAT+1 cycles.
REQ-010 Address decode SHALL be evaluated on the latched address, in priority order:
- latched_addr[1:0] != 0 gives rsp_err=01.
- Otherwise, word index latched_addr>>2 >= DEPTH gives rsp_err=10.
- Otherwise rsp_err=00 and the word is read from the array.
REQ-011 On any rsp_err other than 00, rsp_instr SHALL equal NOP_WORD.
REQ-012 The array read SHALL be sampled on the cycle rsp_valid first rises.
- A prog_we to the same index during WAIT is therefore visible in the response.
- A prog_we during RESP SHALL NOT change the held rsp_instr.
REQ-013 prog_we SHALL be honoured in every state, with one word written per edge.
REQ-014 In IDLE, when prog_we=1 and req_valid=1 in the same cycle, the write SHALL take effect and the request SHALL NOT be accepted; it is retried the following cycle.
REQ-015 While rsp_valid=0, rsp_instr SHALL equal NOP_WORD and rsp_err SHALL equal 00.
REQ-016 busy SHALL equal 1 in WAIT and RESP, and 0 in IDLE.

Reset
REQ-017 Asserting rst_n=0 SHALL immediately force, regardless of clk:
- state = IDLE, latency counter = 0;
- rsp_valid = 0, rsp_instr = NOP_WORD, rsp_err = 00;
- busy = 0, req_ready = 1.
REQ-018 Reset asserted while in WAIT or RESP SHALL discard the in-flight fetch; no response is produced after rst_n returns to 1.
REQ-019 Array contents SHALL be preserved across reset.

Verification
REQ-020 Program then fetch: RD_LAT=2, write word 0 = 32'h58000000 and word 1 = 32'h08100000, then fetch addresses 0 and 4 with rsp_ready held at 1 -> each rsp_valid rises 2 cycles after acceptance with the matching word and rsp_err=00.
REQ-021 Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_instr and rsp_err stay constant and req_ready=0 throughout; one cycle after rsp_ready=1, req_ready=1.
REQ-022 Error paths with DEPTH=64:
- fetch addr 6 -> rsp_err=01, rsp_instr=NOP_WORD;
- fetch addr 256 -> rsp_err=10, rsp_instr=NOP_WORD;
- fetch addr 252 -> rsp_err=00 with the contents of word 63.
REQ-023 Program/fetch collision: in IDLE drive prog_we=1 (word 3 = 32'hDEAD0000) and req_valid=1 (addr 12) together -> request not accepted that cycle; it is accepted the next cycle and returns 32'hDEAD0000.
REQ-024 Reset mid-operation: assert rst_n=0 one cycle after acceptance -> rsp_valid=0 immediately and no response ever appears; after release, a fetch of addr 0 returns the previously programmed word.
REQ-025 Latency sweep: with RD_LAT = 1, 2 and 4 -> acceptance-to-rsp_valid is exactly RD_LAT cycles, checked on back-to-back requests.
